branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Consumer end of the ALU flag interface. Latches Zero/Negative/Carry/OverFlow
//  from the ALU into a flag register and evaluates a branch condition against it.
//  Taken branches drive a redirect to fetch over a valid/ready handshake, then
//  assert flush for a fixed number of cycles.
//  Sits between the ALU and the fetch/PC logic. Keeps taken/not-taken counters.
// PARAMETERS
//  ADDR_W        32  width of PC, offset and target
//  FLUSH_CYCLES  2   cycles flush is held after redirect accepted (0 = none)
//  CNT_W         16  width of taken/not-taken statistic counters
// PORTS
//  clk           in   1       single clock, all state on rising edge
//  rst           in   1       asynchronous, active-high reset
//  flag_we       in   1       capture ALU flags this cycle
//  zero          in   1       ALU Zero
//  negative      in   1       ALU Negative
//  carry         in   1       ALU Carry (SUB: 1 = no borrow, A>=B unsigned)
//  overflow      in   1       ALU OverFlow
//  br_valid      in   1       branch request present
//  br_ready      out  1       unit can accept a request
//  br_cond       in   3       condition code (see BEHAVIOUR)
//  br_pc         in   ADDR_W  PC of branch
//  br_offset     in   ADDR_W  signed byte offset
//  redir_valid   out  1       redirect target valid
//  redir_ready   in   1       fetch accepts redirect
//  redir_target  out  ADDR_W  br_pc + br_offset
//  flush         out  1       squash younger instructions
//  busy          out  1       state != IDLE
//  taken_cnt     out  CNT_W   taken branches, saturating
//  nt_cnt        out  CNT_W   not-taken branches, saturating
// BEHAVIOUR
//  Reset: state=IDLE; flags Z,N,C,V=0; redir_valid=0; redir_target=0; flush=0;
//   busy=0; br_ready=1; counters=0. Reset mid-operation aborts immediately.
//  Flags: on flag_we, register {Z,N,C,V} <= inputs, in any state.
//  Effective flags for evaluation = incoming flags if flag_we same cycle,
//   else registered flags (forwarding).
//  Conditions: 000 EQ Z | 001 NE !Z | 010 LT N^V | 011 GE !(N^V) |
//   100 LTU !C | 101 GEU C | 110 ALWAYS | 111 NEVER.
//  FSM IDLE -> REDIRECT -> FLUSH -> IDLE; br_ready=1 only in IDLE.
//  IDLE: accept on br_valid&&br_ready; evaluate in the acceptance cycle.
//   Not taken: nt_cnt++, stay IDLE, no redirect (back-to-back accepts allowed).
//   Taken: taken_cnt++, redir_target <= (br_pc+br_offset) mod 2^ADDR_W,
//   next cycle REDIRECT.
//  REDIRECT: redir_valid=1. Target stable until redir_valid&&redir_ready.
//   On the handshake: go to FLUSH, or to IDLE if FLUSH_CYCLES=0.
//  FLUSH: flush=1 for exactly FLUSH_CYCLES cycles (down-counter), then IDLE.
//   Redirect-to-IDLE latency >= 1 cycle. redir_valid=0 outside REDIRECT.
//  br_valid outside IDLE is ignored (not accepted). Requester must hold it.
//  Counters saturate at 2^CNT_W-1 and never wrap.
//  Target addition wraps modulo 2^ADDR_W. No overflow flag.
// TESTING
//  1 flag_we with Z=1, then br_valid cond=000 pc=0x100 off=0x20 -> redir_valid
//    next cycle, target=0x120, taken_cnt=1.
//  2 Z=0 registered, cond=000 -> no redirect, nt_cnt=1, br_ready stays 1;
//    three back-to-back NE/LT/NEVER accepted on 3 consecutive cycles.
//  3 SUB 5-10 flags (N=1,V=0,C=0): LT and LTU taken; GE and GEU not taken.
//    Forwarding: flag_we and br_valid same cycle use the new flags.
//  4 redir_ready low 4 cycles -> redir_valid and target held, br_ready=0.
//    Ready high -> flush=1 exactly 2 cycles, then br_ready=1.
//  5 pc=0xFFFFFFF0 off=0x20 -> target=0x00000010.
//    Offset -8 from 0x100 -> 0xF8.
//  6 rst asserted in REDIRECT or FLUSH -> outputs at reset values without a clock
//    edge; CNT_W=2 bench saturates taken_cnt at 3.

Source files
------------

// File: rtl/branch_resolve_unit.sv
//------------------------------------------------------------------------------
// branch_resolve_unit: latches ALU flags, resolves branches, redirects fetch
// and holds flush for a fixed number of cycles afterwards.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module branch_resolve_unit #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flag_we,
  input  logic              zero,
  input  logic              negative,
  input  logic              carry,
  input  logic              overflow,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_cond,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_offset,
  output logic              redir_valid,
  input  logic              redir_ready,
  output logic [ADDR_W-1:0] redir_target,
  output logic              flush,
  output logic              busy,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  nt_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = (FLUSH_CYCLES > 0) ? FC_W'(FLUSH_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t              state_q, state_d;
  logic [3:0]          flags_q, flags_d;      // {Z,N,C,V}
  logic [ADDR_W-1:0]   target_q, target_d;
  logic [FC_W-1:0]     fcnt_q, fcnt_d;
  logic [CNT_W-1:0]    taken_q, taken_d;
  logic [CNT_W-1:0]    nt_q, nt_d;
  logic [3:0]          eff_flags;
  logic                cond_true;

  always_comb begin
    // Flags written this cycle are forwarded into the evaluation.
    eff_flags = flag_we ? {zero, negative, carry, overflow} : flags_q;
    case (br_cond)
      3'b000:  cond_true = eff_flags[3];
      3'b001:  cond_true = ~eff_flags[3];
      3'b010:  cond_true = eff_flags[2] ^ eff_flags[0];
      3'b011:  cond_true = ~(eff_flags[2] ^ eff_flags[0]);
      3'b100:  cond_true = ~eff_flags[1];
      3'b101:  cond_true = eff_flags[1];
      3'b110:  cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    flags_d  = flag_we ? {zero, negative, carry, overflow} : flags_q;
    target_d = target_q;
    fcnt_d   = fcnt_q;
    taken_d  = taken_q;
    nt_d     = nt_q;
    case (state_q)
      ST_IDLE: begin
        if (br_valid) begin
          if (cond_true) begin
            taken_d  = (taken_q == CNT_MAX) ? taken_q : taken_q + 1'b1;
            target_d = br_pc + br_offset;
            state_d  = ST_REDIRECT;
          end else begin
            nt_d = (nt_q == CNT_MAX) ? nt_q : nt_q + 1'b1;
          end
        end
      end
      ST_REDIRECT: begin
        if (redir_ready) begin
          if (FLUSH_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FLUSH;
            fcnt_d  = FC_LOAD;
          end
        end
      end
      ST_FLUSH: begin
        if (fcnt_q == '0) state_d = ST_IDLE;
        else              fcnt_d  = fcnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      flags_q  <= '0;
      target_q <= '0;
      fcnt_q   <= '0;
      taken_q  <= '0;
      nt_q     <= '0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      target_q <= target_d;
      fcnt_q   <= fcnt_d;
      taken_q  <= taken_d;
      nt_q     <= nt_d;
    end
  end

  // Handshake/status outputs decode the state directly so reset clears them at once.
  assign br_ready     = (state_q == ST_IDLE);
  assign redir_valid  = (state_q == ST_REDIRECT);
  assign flush        = (state_q == ST_FLUSH);
  assign busy         = (state_q != ST_IDLE);
  assign redir_target = target_q;
  assign taken_cnt    = taken_q;
  assign nt_cnt       = nt_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
//------------------------------------------------------------------------------
// tb_branch_resolve_unit: directed and random stimulus against a reference model.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_branch_resolve_unit;

  localparam int AW = 32;
  localparam int FC = 2;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flag_we, zero, negative, carry, overflow;
  logic          br_valid, br_ready;
  logic [2:0]    br_cond;
  logic [AW-1:0] br_pc, br_offset;
  logic          redir_valid, redir_ready;
  logic [AW-1:0] redir_target;
  logic          flush, busy;
  logic [CW-1:0] taken_cnt, nt_cnt;

  branch_resolve_unit #(.ADDR_W(AW), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flag_we(flag_we), .zero(zero), .negative(negative),
    .carry(carry), .overflow(overflow), .br_valid(br_valid), .br_ready(br_ready),
    .br_cond(br_cond), .br_pc(br_pc), .br_offset(br_offset),
    .redir_valid(redir_valid), .redir_ready(redir_ready),
    .redir_target(redir_target), .flush(flush), .busy(busy),
    .taken_cnt(taken_cnt), .nt_cnt(nt_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: a pending redirect, remaining flush cycles, flags, counters.
  bit [3:0]      m_flags;   // {Z,N,C,V}
  bit            m_redir;
  int            m_flush_left;
  logic [AW-1:0] m_target;
  int            m_taken, m_nt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic bit cond_holds(input bit [2:0] c, input bit [3:0] f);
    bit z, n, cy, v;
    {z, n, cy, v} = f;
    case (c)
      3'd0: return z;
      3'd1: return !z;
      3'd2: return n != v;
      3'd3: return n == v;
      3'd4: return !cy;
      3'd5: return cy;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_flags = '0; m_redir = 0; m_flush_left = 0; m_target = '0; m_taken = 0; m_nt = 0;
  endtask

  task automatic check_outputs();
    bit idle;
    idle = !m_redir && (m_flush_left == 0);
    check("br_ready", br_ready, idle);
    check("redir_valid", redir_valid, m_redir);
    check("flush", flush, m_flush_left > 0);
    check("busy", busy, !idle);
    check("redir_target", redir_target, m_target);
    check("taken_cnt", taken_cnt, m_taken);
    check("nt_cnt", nt_cnt, m_nt);
  endtask

  task automatic model_step();
    bit [3:0] eff;
    bit idle;
    idle = !m_redir && (m_flush_left == 0);
    eff = flag_we ? {zero, negative, carry, overflow} : m_flags;
    if (flag_we) m_flags = {zero, negative, carry, overflow};
    if (idle) begin
      if (br_valid) begin
        if (cond_holds(br_cond, eff)) begin
          if (m_taken < CMAX) m_taken++;
          m_target = br_pc + br_offset;
          m_redir  = 1;
        end else if (m_nt < CMAX) m_nt++;
      end
    end else if (m_redir) begin
      if (redir_ready) begin
        m_redir = 0;
        m_flush_left = FC;
      end
    end else m_flush_left--;
  endtask

  // One clock: drive, compare at the falling edge, advance model, pass the rising edge.
  task automatic cyc(input bit fw, input bit [3:0] f, input bit bv, input bit [2:0] c,
                     input logic [AW-1:0] pc, input logic [AW-1:0] off, input bit rr);
    flag_we = fw; {zero, negative, carry, overflow} = f;
    br_valid = bv; br_cond = c; br_pc = pc; br_offset = off; redir_ready = rr;
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc(input bit rr);
    cyc(0, 4'b0, 0, 3'd7, '0, '0, rr);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_br_ready"}, br_ready, 1);
    check({tag, "_redir_valid"}, redir_valid, 0);
    check({tag, "_flush"}, flush, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_target"}, redir_target, 0);
    check({tag, "_taken"}, taken_cnt, 0);
    check({tag, "_nt"}, nt_cnt, 0);
  endtask

  initial begin
    rst = 1; flag_we = 0; {zero, negative, carry, overflow} = 4'b0;
    br_valid = 0; br_cond = 3'd7; br_pc = '0; br_offset = '0; redir_ready = 0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1; rst = 0;

    // Registered Z=1 then EQ branch taken.
    cyc(1, 4'b1000, 0, 3'd7, '0, '0, 0);
    cyc(0, 4'b0, 1, 3'd0, 32'h100, 32'h20, 0);
    check("t1_redir_valid", redir_valid, 1);
    check("t1_target", redir_target, 32'h120);
    check("t1_taken", taken_cnt, 1);
    idle_cyc(1); idle_cyc(0); idle_cyc(0);

    // Z=0: EQ not taken; then Z=1 and NE/LT/NEVER back-to-back, all not taken.
    cyc(1, 4'b0000, 0, 3'd7, '0, '0, 0);
    cyc(0, 4'b0, 1, 3'd0, 32'h200, 32'h4, 0);
    check("t2_nt1", nt_cnt, 1);
    check("t2_ready", br_ready, 1);
    cyc(1, 4'b1000, 0, 3'd7, '0, '0, 0);
    cyc(0, 4'b0, 1, 3'd1, 32'h300, 32'h4, 0);
    cyc(0, 4'b0, 1, 3'd2, 32'h304, 32'h4, 0);
    cyc(0, 4'b0, 1, 3'd7, 32'h308, 32'h4, 0);
    check("t2_nt_sat", nt_cnt, 3);
    check("t2_ready_after", br_ready, 1);

    // 5-10 flags forwarded in the same cycle: LT taken despite registered Z=1,N=0.
    cyc(1, 4'b0100, 1, 3'd2, 32'h400, 32'h40, 0);
    check("t3_lt_fwd", redir_valid, 1);
    idle_cyc(1); idle_cyc(0); idle_cyc(0);
    cyc(0, 4'b0, 1, 3'd4, 32'h500, 32'h10, 0);
    check("t3_ltu", redir_valid, 1);
    idle_cyc(1); idle_cyc(0); idle_cyc(0);
    cyc(0, 4'b0, 1, 3'd3, 32'h600, 32'h10, 0);
    check("t3_ge", redir_valid, 0);
    cyc(0, 4'b0, 1, 3'd5, 32'h604, 32'h10, 0);
    check("t3_geu", redir_valid, 0);

    // Stalled redirect with br_valid held, then ack and two flush cycles.
    cyc(0, 4'b0, 1, 3'd6, 32'h700, 32'h80, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 4'b0, 1, 3'd6, 32'h900, 32'h4, 0);
      check("t4_hold_valid", redir_valid, 1);
      check("t4_hold_target", redir_target, 32'h780);
      check("t4_hold_ready", br_ready, 0);
    end
    idle_cyc(1);
    check("t4_flush1", flush, 1);
    idle_cyc(0);
    check("t4_flush2", flush, 1);
    idle_cyc(0);
    check("t4_flush_end", flush, 0);
    check("t4_ready_back", br_ready, 1);

    // Target wrap and negative offset.
    cyc(0, 4'b0, 1, 3'd6, 32'hFFFF_FFF0, 32'h20, 0);
    check("t5_wrap", redir_target, 32'h10);
    idle_cyc(1); idle_cyc(0); idle_cyc(0);
    cyc(0, 4'b0, 1, 3'd6, 32'h100, 32'hFFFF_FFF8, 0);
    check("t5_neg", redir_target, 32'hF8);

    // Asynchronous reset while in REDIRECT, away from any clock edge.
    #2 rst = 1;
    #1 check_reset_outputs("rst_redir");
    model_reset();
    @(posedge clk); #1; rst = 0;

    // Asynchronous reset while in FLUSH.
    cyc(0, 4'b0, 1, 3'd6, 32'h40, 32'h4, 0);
    idle_cyc(1);
    check("t6_in_flush", flush, 1);
    #2 rst = 1;
    #1 check_reset_outputs("rst_flush");
    model_reset();
    @(posedge clk); #1; rst = 0;

    // Taken counter saturation.
    for (int i = 0; i < 4; i++) begin
      cyc(0, 4'b0, 1, 3'd6, 32'h1000, 32'h10, 0);
      idle_cyc(1); idle_cyc(0); idle_cyc(0);
    end
    check("t6_taken_sat", taken_cnt, 3);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 9) < 3), 4'($urandom), $urandom_range(0, 1), 3'($urandom),
          $urandom, $urandom, $urandom_range(0, 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
